// File: rtl/door_scheduler.sv
// Door sequencing controller: round-robin requester arbitration, hold-open timer, obstruction
// re-open, travel watchdog and latched fault. All outputs registered.
module door_scheduler #(
  parameter int N_REQ          = 4,
  parameter int HOLD_CYCLES    = 50,
  parameter int TRAVEL_TIMEOUT = 200,
  parameter int CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  input  logic             OBSTRUCT,
  input  logic             CLR_FAULT,
  input  logic             UP_Max,
  input  logic             DN_Max,
  output logic             Activate,
  output logic [N_REQ-1:0] GRANT,
  output logic             DOOR_OPEN,
  output logic             BUSY,
  output logic             FAULT
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TRAVEL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OPENING, S_HOLD_OPEN, S_CLOSING, S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic               reopen_q, reopen_d;
  logic               activate_q, act_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               door_open_q, busy_q, fault_q;

  logic [N_REQ-1:0]   win_oh;
  logic [PTR_W-1:0]   win_ptr;
  logic [PTR_W-1:0]   idx;
  logic               any_req;

  // Round-robin search starting at rr_q; first set request wins.
  always_comb begin
    win_oh  = '0;
    win_ptr = rr_q;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(rr_q) + k) % N_REQ);
      if (!any_req && REQ[idx]) begin
        any_req     = 1'b1;
        win_oh[idx] = 1'b1;
        win_ptr     = PTR_W'((int'(rr_q) + k + 1) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    reopen_d = reopen_q;
    act_d    = 1'b0;
    grant_d  = '0;
    if (UP_Max && DN_Max) begin
      state_d  = S_FAULT;
      cnt_d    = '0;
      reopen_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DN_Max) begin
            cnt_d = '0;
            if (any_req) begin
              grant_d = win_oh;
              rr_d    = win_ptr;
              act_d   = 1'b1;
              state_d = S_OPENING;
            end
          end else if (UP_Max) begin
            state_d = S_HOLD_OPEN;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_FAULT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_OPENING: begin
          if (UP_Max) begin
            state_d = S_HOLD_OPEN;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_FAULT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_HOLD_OPEN: begin
          if (OBSTRUCT || any_req) begin
            cnt_d = '0;
            if (any_req) begin
              grant_d = win_oh;
              rr_d    = win_ptr;
            end
          end else if (cnt_q == HOLD_LAST) begin
            act_d    = 1'b1;
            cnt_d    = '0;
            reopen_d = 1'b0;
            state_d  = S_CLOSING;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CLOSING: begin
          reopen_d = reopen_q | OBSTRUCT;
          // The limit is ignored on the cycle right after the close pulse so Activate never repeats.
          if (DN_Max && !activate_q) begin
            cnt_d    = '0;
            reopen_d = 1'b0;
            if (reopen_q || OBSTRUCT) begin
              act_d   = 1'b1;
              state_d = S_OPENING;
            end else begin
              state_d = S_IDLE;
            end
          end else if (cnt_q == TO_LAST) begin
            state_d  = S_FAULT;
            cnt_d    = '0;
            reopen_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FAULT: begin
          if (CLR_FAULT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_q        <= '0;
      reopen_q    <= 1'b0;
      activate_q  <= 1'b0;
      grant_q     <= '0;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      reopen_q    <= reopen_d;
      activate_q  <= act_d;
      grant_q     <= grant_d;
      door_open_q <= (state_d == S_HOLD_OPEN);
      busy_q      <= (state_d == S_OPENING) || (state_d == S_HOLD_OPEN) || (state_d == S_CLOSING);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign Activate  = activate_q;
  assign GRANT     = grant_q;
  assign DOOR_OPEN = door_open_q;
  assign BUSY      = busy_q;
  assign FAULT     = fault_q;

endmodule
